// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store controller: sequences the data memory's setup/strobe/hold
// protocol, performs read-modify-write for single-word stores and returns a response.
module dmem_access_ctrl #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int DEPTH  = 256,
   parameter int TAG_W  = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   input  logic [TAG_W-1:0]    req_tag,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [2*DATA_W-1:0] mem_write_data,
   output logic                mem_read_en,
   output logic                mem_write_en,
   output logic                mem_en,
   input  logic [DATA_W-1:0]   mem_read_data,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_data,
   output logic [TAG_W-1:0]    resp_tag,
   output logic                resp_err
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
   // A request is accepted only in IDLE; a response is held unchanged until resp_ready.

   localparam logic [1:0]        OP_LOAD   = 2'b01;
   localparam logic [1:0]        OP_STP    = 2'b11;
   localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE, RD_SETUP, RD_STROBE, RD_CAPT, WR_SETUP, WR_STROBE, RESP
   } state_t;

   state_t state, state_nx;

   logic [1:0]          op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [2*DATA_W-1:0] wdata_q;
   logic [TAG_W-1:0]    tag_q;

   logic                accept;
   logic                req_illegal;
   logic [1:0]          op_c;
   logic [ADDR_W-1:0]   addr_c;
   logic [ADDR_W-1:0]   rd_addr;
   logic [2*DATA_W-1:0] wdata_c;
   logic [TAG_W-1:0]    tag_c;

   logic [ADDR_W-1:0]   addr_nx;
   logic [2*DATA_W-1:0] wdata_nx;
   logic                rd_en_nx, wr_en_nx, en_nx;
   logic                rvalid_nx, rerr_nx;
   logic [DATA_W-1:0]   rdata_nx;
   logic [TAG_W-1:0]    rtag_nx;

   assign accept      = (state == IDLE) && req_valid && req_ready;
   assign req_illegal = (req_op == 2'b00) || (req_addr >= DEPTH_A) ||
                        (req_op[1] && (req_addr == LAST_ADDR));

   // Outputs are registered from the next state, so the accept edge already needs
   // the live request fields; afterwards the latched copies are used.
   assign op_c    = (state == IDLE) ? req_op    : op_q;
   assign addr_c  = (state == IDLE) ? req_addr  : addr_q;
   assign wdata_c = (state == IDLE) ? req_wdata : wdata_q;
   assign tag_c   = (state == IDLE) ? req_tag   : tag_q;
   assign rd_addr = (op_c == OP_LOAD) ? addr_c : addr_c + ADDR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_illegal)           state_nx = RESP;
               else if (req_op == OP_STP) state_nx = WR_SETUP;
               else                       state_nx = RD_SETUP;
            end
         end
         RD_SETUP:  state_nx = RD_STROBE;
         RD_STROBE: state_nx = RD_CAPT;
         RD_CAPT:   state_nx = (op_q == OP_LOAD) ? RESP : WR_SETUP;
         WR_SETUP:  state_nx = WR_STROBE;
         WR_STROBE: state_nx = RESP;
         RESP:      if (resp_ready) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_comb begin
      addr_nx   = mem_address;
      wdata_nx  = mem_write_data;
      rd_en_nx  = 1'b0;
      wr_en_nx  = 1'b0;
      en_nx     = 1'b0;
      rvalid_nx = resp_valid;
      rdata_nx  = resp_data;
      rtag_nx   = resp_tag;
      rerr_nx   = resp_err;
      case (state_nx)
         RD_SETUP, RD_STROBE, RD_CAPT: begin
            addr_nx  = rd_addr;
            rd_en_nx = 1'b1;
            en_nx    = (state_nx == RD_STROBE);
         end
         WR_SETUP, WR_STROBE: begin
            addr_nx  = addr_c;
            wr_en_nx = 1'b1;
            en_nx    = (state_nx == WR_STROBE);
            // Single-word store rewrites addr+1 with the old word captured by the read.
            if (state_nx == WR_SETUP)
               wdata_nx = (op_c == OP_STP) ? wdata_c : {mem_read_data, wdata_c[DATA_W-1:0]};
         end
         RESP: begin
            if (state != RESP) begin
               rvalid_nx = 1'b1;
               rerr_nx   = (state == IDLE);
               rdata_nx  = (state == RD_CAPT) ? mem_read_data : '0;
               rtag_nx   = tag_c;
            end
         end
         default: rvalid_nx = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q           <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         tag_q          <= '0;
         req_ready      <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         mem_read_en    <= 1'b0;
         mem_write_en   <= 1'b0;
         mem_en         <= 1'b0;
         resp_valid     <= 1'b0;
         resp_data      <= '0;
         resp_tag       <= '0;
         resp_err       <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            tag_q   <= req_tag;
         end
         req_ready      <= (state_nx == IDLE);
         mem_address    <= addr_nx;
         mem_write_data <= wdata_nx;
         mem_read_en    <= rd_en_nx;
         mem_write_en   <= wr_en_nx;
         mem_en         <= en_nx;
         resp_valid     <= rvalid_nx;
         resp_data      <= rdata_nx;
         resp_tag       <= rtag_nx;
         resp_err       <= rerr_nx;
      end
   end

endmodule
